vc_job_master: RTL



---
 rtl/vc_job_master.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vc_job_master.sv
// vc_job_master: runs one vector job on a videocard. Writes length, base and
// data into videocard RAM, kicks the card, polls its status register and
// streams the processed vector back out.
//
// Ports:
//   clk, reset_sink_reset_n          clock, synchronous active-low reset
//   job_valid/job_ready/job_len      job request handshake and vector length
//   in_data/in_valid/in_ready        input element stream
//   out_data/out_valid/out_ready/
//   out_last                         result element stream
//   busy, done, err                  job status (done is a 1-cycle pulse,
//                                    err qualifies done)
//   address/data_out/data_in/
//   write/read/byteenable            videocard RAM port
//   address_control/data_out_control/
//   data_in_control/write_control/
//   read_control                     videocard control port
//
// Optional feature: define VC_JOB_TIMEOUT_EN to give up after TIMEOUT status
// polls without the done bit (job finishes with err=1, no readback).
module vc_job_master #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 16,
    parameter int DATA_BASE = 2,
    parameter int POLL_GAP  = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset_sink_reset_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_len,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  data_out,
    input  logic [WIDTH-1:0]  data_in,
    output logic              write,
    output logic              read,
    output logic [3:0]        byteenable,
    output logic              address_control,
    output logic [WIDTH-1:0]  data_out_control,
    input  logic [WIDTH-1:0]  data_in_control,
    output logic              write_control,
    output logic              read_control
);

    // Parameter sanity checks at elaboration.
    if (POLL_GAP < 1) begin : g_gap_chk
        $error("POLL_GAP must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_tmo_chk
        $error("TIMEOUT must be >= 1");
    end
    if (WIDTH < ADDR_W) begin : g_width_chk
        $error("WIDTH must be >= ADDR_W");
    end

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        IDLE,
        WR_LEN,
        WR_BASE,
        WR_DATA,
        KICK,
        POLL_RD,
        POLL_WAIT,
        GAP,
        RD_REQ,
        RD_WAIT,
        RD_OUT,
        FIN
    } state_t;

    state_t            state_q, state_nx;
    logic [ADDR_W-1:0] len_q, len_nx;
    logic [ADDR_W-1:0] idx_q, idx_nx;
    logic [GAP_W-1:0]  gap_q, gap_nx;
    logic [WIDTH-1:0]  rd_q, rd_nx;
    logic              err_q, err_nx;

`ifdef VC_JOB_TIMEOUT_EN
    localparam int POLL_W = $clog2(TIMEOUT + 1);
    logic [POLL_W-1:0] poll_q, poll_nx;
`endif

    // Only bit 0 of the status register carries meaning.
    logic unused_status;
    assign unused_status = ^data_in_control[WIDTH-1:1];

    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] data_addr;
    logic              at_last;

    // Element addresses wrap modulo 2^ADDR_W by construction.
    assign last_idx   = len_q - ADDR_W'(1);
    assign data_addr  = ADDR_W'(DATA_BASE) + idx_q;
    assign at_last    = (idx_q == last_idx);
    assign byteenable = 4'b1111;

    always_ff @(posedge clk) begin
        if (!reset_sink_reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef VC_JOB_TIMEOUT_EN
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_nx;
            len_q   <= len_nx;
            idx_q   <= idx_nx;
            gap_q   <= gap_nx;
            rd_q    <= rd_nx;
            err_q   <= err_nx;
`ifdef VC_JOB_TIMEOUT_EN
            poll_q  <= poll_nx;
`endif
        end
    end

    always_comb begin
        state_nx         = state_q;
        len_nx           = len_q;
        idx_nx           = idx_q;
        gap_nx           = gap_q;
        rd_nx            = rd_q;
        err_nx           = err_q;
`ifdef VC_JOB_TIMEOUT_EN
        poll_nx          = poll_q;
`endif
        job_ready        = 1'b0;
        in_ready         = 1'b0;
        out_data         = '0;
        out_valid        = 1'b0;
        out_last         = 1'b0;
        busy             = (state_q != IDLE);
        done             = 1'b0;
        err              = 1'b0;
        address          = '0;
        data_out         = '0;
        write            = 1'b0;
        read             = 1'b0;
        address_control  = 1'b0;
        data_out_control = '0;
        write_control    = 1'b0;
        read_control     = 1'b0;

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    len_nx = job_len;
                    idx_nx = '0;
`ifdef VC_JOB_TIMEOUT_EN
                    poll_nx = '0;
`endif
                    // An empty job never touches the card.
                    if (job_len == '0) begin
                        err_nx   = 1'b1;
                        state_nx = FIN;
                    end else begin
                        err_nx   = 1'b0;
                        state_nx = WR_LEN;
                    end
                end
            end

            WR_LEN: begin
                write    = 1'b1;
                address  = '0;
                data_out = WIDTH'(len_q);
                state_nx = WR_BASE;
            end

            WR_BASE: begin
                write    = 1'b1;
                address  = ADDR_W'(1);
                data_out = WIDTH'(DATA_BASE);
                state_nx = WR_DATA;
            end

            WR_DATA: begin
                in_ready = 1'b1;
                address  = data_addr;
                data_out = in_data;
                write    = in_valid;
                if (in_valid) begin
                    if (at_last) begin
                        idx_nx   = '0;
                        state_nx = KICK;
                    end else begin
                        idx_nx = idx_q + ADDR_W'(1);
                    end
                end
            end

            KICK: begin
                write_control    = 1'b1;
                address_control  = 1'b0;
                data_out_control = WIDTH'(1);
                state_nx         = POLL_RD;
            end

            POLL_RD: begin
                read_control    = 1'b1;
                address_control = 1'b1;
`ifdef VC_JOB_TIMEOUT_EN
                poll_nx = poll_q + POLL_W'(1);
`endif
                state_nx = POLL_WAIT;
            end

            POLL_WAIT: begin
                // Status read data arrives one cycle after the read strobe.
                if (data_in_control[0]) begin
                    idx_nx   = '0;
                    state_nx = RD_REQ;
`ifdef VC_JOB_TIMEOUT_EN
                end else if (poll_q == POLL_W'(TIMEOUT)) begin
                    err_nx   = 1'b1;
                    state_nx = FIN;
`endif
                end else begin
                    gap_nx   = '0;
                    state_nx = GAP;
                end
            end

            GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_nx = POLL_RD;
                end else begin
                    gap_nx = gap_q + GAP_W'(1);
                end
            end

            RD_REQ: begin
                read     = 1'b1;
                address  = data_addr;
                state_nx = RD_WAIT;
            end

            RD_WAIT: begin
                rd_nx    = data_in;
                state_nx = RD_OUT;
            end

            RD_OUT: begin
                out_valid = 1'b1;
                out_data  = rd_q;
                out_last  = at_last;
                if (out_ready) begin
                    if (at_last) begin
                        state_nx = FIN;
                    end else begin
                        idx_nx   = idx_q + ADDR_W'(1);
                        state_nx = RD_REQ;
                    end
                end
            end

            FIN: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule
